mmio_mem_ctrl: RTL and testbench
================================

// Module: mmio_mem_ctrl
// PURPOSE
//   Parametrised core-side memory/MMIO dispatcher; successor to the fixed 4-peripheral dispatcher.
//   Routes core accesses to external sync-read RAM (port A) or to N_PERIPH shadow registers.
//   Each shadow register keeps a sticky "fresh" flag; a core read clears it and pulses periph_rd.
//   Read data for RAM and MMIO is aligned to one fixed latency. VGA stays on RAM port B, outside.
// PARAMETERS
//   ADDR_W      24        core address width
//   DATA_W      16        data width (also the status-register width, so N_PERIPH <= DATA_W)
//   RAM_AW      15        RAM address width; core_addr < 2**RAM_AW selects RAM
//   N_PERIPH    4         number of peripheral channels, 1..DATA_W
//   PERIPH_BASE 24'h8000  channel i at PERIPH_BASE+i; status register at PERIPH_BASE+N_PERIPH
// PORTS
//   clk          in   1                  system clock, rising edge
//   rst          in   1                  async active-high reset
//   core_we      in   1                  core write strobe (1 cycle per access)
//   core_re      in   1                  core read strobe (1 cycle per access)
//   core_addr    in   ADDR_W             core byte-free word address
//   core_wdata   in   DATA_W             core write data
//   core_rdata   out  DATA_W             read data, valid with core_rvalid
//   core_rvalid  out  1                  1-cycle pulse, 2 cycles after core_re
//   ram_we       out  1                  RAM port A write enable (combinational)
//   ram_addr     out  RAM_AW             RAM port A address (core_addr[RAM_AW-1:0])
//   ram_wdata    out  DATA_W             RAM port A write data
//   ram_rdata    in   DATA_W             RAM port A read data, 1 cycle after address
//   periph_data  in   N_PERIPH*DATA_W    channel i at [i*DATA_W +: DATA_W]
//   periph_upd   in   N_PERIPH           per-channel new-sample strobe
//   periph_rd    out  N_PERIPH           1-cycle pulse: channel i read by core
//   periph_fresh out  N_PERIPH           sticky unread-sample flags
// BEHAVIOUR
//   - Reset: core_rdata=0, core_rvalid=0, periph_rd=0, periph_fresh=0, all shadow regs=0, pipe empty.
//   - Decode: RAM if addr < 2**RAM_AW; CH[i] if addr==PERIPH_BASE+i; STAT if addr==PERIPH_BASE+N_PERIPH;
//     else UNMAPPED. ram_we = core_we & RAM hit. Writes to CH[i] and UNMAPPED are ignored.
//   - Capture: periph_upd[i] -> shadow[i]<=periph_data slice, fresh[i]<=1 (next edge).
//   - Read pipe. Stage 1 (edge after core_re): register the decoded select. For a CH[i] read, also
//     register the shadow[i] snapshot, clear fresh[i], and pulse periph_rd[i].
//   - Read pipe. Stage 2: core_rdata <= ram_rdata, CH snapshot, {0,fresh}, or 0; core_rvalid=1.
//     Latency is 2 edges for every target. One read may be issued per cycle (fully pipelined).
//   - STAT write: write-1-to-clear, fresh[i] <= fresh[i] & ~core_wdata[i].
//   - Same-cycle periph_upd[i] and CH[i] read: the read returns the OLD value; the new value is
//     captured; fresh[i] ends at 1 (update wins); periph_rd[i] still pulses.
//   - Same-cycle periph_upd[i] and STAT W1C of bit i: update wins, so fresh[i]=1.
//   - core_we & core_re together: the write is performed, the read is dropped (no rvalid, no clear).
//   - STAT read returns fresh sampled at the stage-1 edge, before that edge's clears/sets.
//   - Reset asserted mid-pipe: in-flight reads are discarded; no rvalid after reset release.
// CONFIGURATION
//   MMIO_ERR_EN defined: adds output err_cnt[7:0] and output err_flag.
//     - err_cnt: saturating count of UNMAPPED accesses (read or write); saturates at 8'hFF.
//     - err_flag: sticky bit, set on the first UNMAPPED access.
//     - A STAT write with core_wdata[DATA_W-1]=1 clears both; a same-cycle error still counts (=1).
//     - Both reset to 0.
//   MMIO_ERR_EN undefined: these ports and their logic are absent.
//     - UNMAPPED accesses are silent: read returns 0, write is ignored.
// TESTING
//   1. Write RAM 0x0010=0xBEEF, then read 0x0010 -> ram_we=1 on write; rdata=0xBEEF, rvalid 2 cycles later.
//   2. periph_upd[2] with data 0x1234, then read PERIPH_BASE+2 -> rdata=0x1234; periph_rd=4'b0100
//      for 1 cycle; fresh[2] 1->0.
//   3. Same-cycle upd[1] (0x00AA, old 0x0055) and read CH1 -> rdata=0x0055; fresh[1]=1; shadow=0x00AA.
//   4. Set fresh=4'b1111, write STAT 0x0005, read STAT -> rdata=0x000A.
//   5. Back-to-back reads RAM, CH0, STAT, 0xFFFFFF -> 4 consecutive rvalid cycles with the correct
//      data in order; the last returns 0.
//   6. (MMIO_ERR_EN) 300 UNMAPPED reads -> err_cnt=0xFF, err_flag=1; STAT write 0x8000 -> both 0.
//      Reset during stage 1 -> no rvalid.

Source files
------------

// File: rtl/mmio_mem_ctrl.sv
// mmio_mem_ctrl: core-side dispatcher between external sync-read RAM (port A)
// and N_PERIPH shadowed peripheral channels plus a fresh-flag status register.
// All reads return through a two-edge pipeline, whatever the target.
// Optional build macro MMIO_ERR_EN adds an unmapped-access counter (err_cnt)
// and a sticky error flag (err_flag).
module mmio_mem_ctrl #(
    parameter int                ADDR_W      = 24,
    parameter int                DATA_W      = 16,
    parameter int                RAM_AW      = 15,
    parameter int                N_PERIPH    = 4,
    parameter logic [ADDR_W-1:0] PERIPH_BASE = 24'h8000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core_we,
    input  logic                         core_re,
    input  logic [ADDR_W-1:0]            core_addr,
    input  logic [DATA_W-1:0]            core_wdata,
    output logic [DATA_W-1:0]            core_rdata,
    output logic                         core_rvalid,
    output logic                         ram_we,
    output logic [RAM_AW-1:0]            ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    input  logic [DATA_W-1:0]            ram_rdata,
    input  logic [N_PERIPH*DATA_W-1:0]   periph_data,
    input  logic [N_PERIPH-1:0]          periph_upd,
    output logic [N_PERIPH-1:0]          periph_rd,
    output logic [N_PERIPH-1:0]          periph_fresh
`ifdef MMIO_ERR_EN
    ,
    output logic [7:0]                   err_cnt,
    output logic                         err_flag
`endif
);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_CH,
        SEL_STAT
    } sel_t;

    sel_t                sel;
    sel_t                s1_sel;
    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;
    logic [DATA_W-1:0]   ch_snap;
    logic [N_PERIPH-1:0] hit_ch;
    logic [N_PERIPH-1:0] rd_ch;
    logic [N_PERIPH-1:0] fresh;
    logic [N_PERIPH-1:0] fresh_next;
    logic [DATA_W-1:0]   shadow [N_PERIPH];
    logic                rd_fire;
    logic                stat_wr;

    // A simultaneous write wins over the read, so the read never enters the pipe.
    assign rd_fire      = core_re & ~core_we;
    assign stat_wr      = core_we & (sel == SEL_STAT);
    assign rd_ch        = {N_PERIPH{rd_fire}} & hit_ch;
    assign ram_we       = core_we & (sel == SEL_RAM);
    assign ram_addr     = core_addr[RAM_AW-1:0];
    assign ram_wdata    = core_wdata;
    assign periph_fresh = fresh;

    // Address decode; RAM takes priority, then channels, then the status register.
    always_comb begin
        hit_ch  = '0;
        ch_snap = '0;
        for (int i = 0; i < N_PERIPH; i++) begin
            if (core_addr == PERIPH_BASE + ADDR_W'(i)) begin
                hit_ch[i] = 1'b1;
                ch_snap   = ch_snap | shadow[i];
            end
        end
        if ((core_addr >> RAM_AW) == '0) begin
            sel = SEL_RAM;
        end else if (|hit_ch) begin
            sel = SEL_CH;
        end else if (core_addr == PERIPH_BASE + ADDR_W'(N_PERIPH)) begin
            sel = SEL_STAT;
        end else begin
            sel = SEL_NONE;
        end
    end

    // Fresh flags: W1C and read-clear first, then a new sample sets, so updates always win.
    always_comb begin
        fresh_next = fresh;
        if (stat_wr) begin
            fresh_next = fresh_next & ~core_wdata[N_PERIPH-1:0];
        end
        fresh_next = (fresh_next & ~rd_ch) | periph_upd;
    end

    // Shadow capture, fresh flags and the one-cycle read-notify pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_PERIPH; i++) begin
                shadow[i] <= '0;
            end
            fresh     <= '0;
            periph_rd <= '0;
        end else begin
            for (int i = 0; i < N_PERIPH; i++) begin
                if (periph_upd[i]) begin
                    shadow[i] <= periph_data[i*DATA_W +: DATA_W];
                end
            end
            fresh     <= fresh_next;
            periph_rd <= rd_ch;
        end
    end

    // Read stage 1: hold the target and snapshot channel/status data before this edge's updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sel   <= SEL_NONE;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            s1_sel   <= sel;
            if (sel == SEL_CH) begin
                s1_data <= ch_snap;
            end else if (sel == SEL_STAT) begin
                s1_data <= DATA_W'(fresh);
            end else begin
                s1_data <= '0;
            end
        end
    end

    // Read stage 2: RAM data arrives during stage 1, so both paths line up here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rvalid <= 1'b0;
            core_rdata  <= '0;
        end else begin
            core_rvalid <= s1_valid;
            if (s1_valid) begin
                core_rdata <= (s1_sel == SEL_RAM) ? ram_rdata : s1_data;
            end
        end
    end

`ifdef MMIO_ERR_EN
    logic err_hit;
    logic err_clr;

    assign err_hit = (core_we | core_re) & (sel == SEL_NONE);
    assign err_clr = stat_wr & core_wdata[DATA_W-1];

    // Saturating unmapped-access counter and sticky flag; a clear still records a same-cycle error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt  <= 8'd0;
            err_flag <= 1'b0;
        end else if (err_clr) begin
            err_cnt  <= err_hit ? 8'd1 : 8'd0;
            err_flag <= err_hit;
        end else if (err_hit) begin
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
            err_flag <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mmio_mem_ctrl.sv
// tb_mmio_mem_ctrl: directed stimulus for mmio_mem_ctrl with a read-response
// scoreboard. Each issued read pushes its hand-computed data and due cycle;
// a monitor pops and compares whenever core_rvalid is seen.
// With MMIO_ERR_EN defined the error counter/flag are exercised as well.
module tb_mmio_mem_ctrl;

    localparam int          ADDR_W   = 24;
    localparam int          DATA_W   = 16;
    localparam int          RAM_AW   = 15;
    localparam int          N_PERIPH = 4;
    localparam logic [23:0] BASE     = 24'h8000;

    typedef struct {
        logic [15:0] data;
        int          due;
        string       name;
    } exp_t;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       core_we;
    logic                       core_re;
    logic [ADDR_W-1:0]          core_addr;
    logic [DATA_W-1:0]          core_wdata;
    logic [DATA_W-1:0]          core_rdata;
    logic                       core_rvalid;
    logic                       ram_we;
    logic [RAM_AW-1:0]          ram_addr;
    logic [DATA_W-1:0]          ram_wdata;
    logic [DATA_W-1:0]          ram_rdata;
    logic [N_PERIPH*DATA_W-1:0] periph_data;
    logic [N_PERIPH-1:0]        periph_upd;
    logic [N_PERIPH-1:0]        periph_rd;
    logic [N_PERIPH-1:0]        periph_fresh;
`ifdef MMIO_ERR_EN
    logic [7:0]                 err_cnt;
    logic                       err_flag;
`endif

    logic [15:0] mem [0:32767];
    exp_t        sb [$];
    exp_t        mon_e;
    int          cyc     = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          rv_seen = 0;
    int          rv_mark;

    always #5 clk = ~clk;

    // Cycle counter used to verify read latency.
    always @(posedge clk) cyc <= cyc + 1;

    // External sync-read RAM model on port A.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    mmio_mem_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_AW(RAM_AW),
        .N_PERIPH(N_PERIPH), .PERIPH_BASE(BASE)
    ) dut (
        .clk(clk), .rst(rst),
        .core_we(core_we), .core_re(core_re), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .periph_data(periph_data), .periph_upd(periph_upd),
        .periph_rd(periph_rd), .periph_fresh(periph_fresh)
`ifdef MMIO_ERR_EN
        , .err_cnt(err_cnt), .err_flag(err_flag)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input logic [23:0] addr, input logic [15:0] exp, input string name);
        exp_t e;
        e.data = exp;
        e.due  = cyc + 2;
        e.name = name;
        sb.push_back(e);
        core_re   = 1'b1;
        core_addr = addr;
        tick();
        core_re = 1'b0;
    endtask

    task automatic write_word(input logic [23:0] addr, input logic [15:0] data);
        core_we    = 1'b1;
        core_addr  = addr;
        core_wdata = data;
        tick();
        core_we = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        tick();
        check_output({name, " drain"}, sb.size(), 0);
    endtask

    // Monitor: every rvalid must match the oldest outstanding expectation, on its due cycle.
    always @(negedge clk) begin
        if (core_rvalid) begin
            rv_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected rvalid: got rdata 0x%0h, expected no response", core_rdata);
            end else begin
                mon_e = sb.pop_front();
                check_output({mon_e.name, " data"}, core_rdata, mon_e.data);
                check_output({mon_e.name, " latency"}, cyc, mon_e.due);
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        rst         = 1'b1;
        core_we     = 1'b0;
        core_re     = 1'b0;
        core_addr   = '0;
        core_wdata  = '0;
        periph_data = '0;
        periph_upd  = '0;
        tick();
        tick();
        check_output("reset rvalid", core_rvalid, 0);
        check_output("reset rdata", core_rdata, 0);
        check_output("reset fresh", periph_fresh, 0);
        check_output("reset periph_rd", periph_rd, 0);
        rst = 1'b0;
        tick();

        // RAM write then read back
        core_we    = 1'b1;
        core_addr  = 24'h000010;
        core_wdata = 16'hBEEF;
        #1;
        check_output("ram_we on RAM write", ram_we, 1);
        check_output("ram_addr", ram_addr, 15'h0010);
        tick();
        core_we = 1'b0;
        issue_read(24'h000010, 16'hBEEF, "ram read");
        drain("ram");

        // Channel 2 capture and read
        periph_data[2*16 +: 16] = 16'h1234;
        periph_upd = 4'b0100;
        tick();
        periph_upd = 4'b0000;
        check_output("fresh after upd2", periph_fresh, 4'b0100);
        issue_read(BASE + 24'd2, 16'h1234, "ch2 read");
        check_output("periph_rd ch2", periph_rd, 4'b0100);
        check_output("fresh after ch2 read", periph_fresh, 4'b0000);
        tick();
        check_output("periph_rd pulse end", periph_rd, 4'b0000);
        drain("ch2");

        // Same-cycle update and read of channel 1 returns the old value
        periph_data[1*16 +: 16] = 16'h0055;
        periph_upd = 4'b0010;
        tick();
        periph_data[1*16 +: 16] = 16'h00AA;
        periph_upd = 4'b0010;
        issue_read(BASE + 24'd1, 16'h0055, "ch1 old");
        periph_upd = 4'b0000;
        check_output("fresh1 update wins", periph_fresh, 4'b0010);
        check_output("periph_rd ch1", periph_rd, 4'b0010);
        issue_read(BASE + 24'd1, 16'h00AA, "ch1 new");
        drain("ch1");
        check_output("fresh after ch1 reread", periph_fresh, 4'b0000);

        // Status W1C and readback
        periph_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        periph_upd  = 4'b1111;
        tick();
        periph_upd = 4'b0000;
        check_output("fresh all set", periph_fresh, 4'b1111);
        write_word(BASE + 24'd4, 16'h0005);
        check_output("fresh after W1C", periph_fresh, 4'b1010);
        issue_read(BASE + 24'd4, 16'h000A, "stat read");
        drain("stat");
        check_output("stat read no clear", periph_fresh, 4'b1010);

        // Back-to-back reads across all target kinds
        issue_read(24'h000010, 16'hBEEF, "b2b ram");
        issue_read(BASE, 16'h1111, "b2b ch0");
        issue_read(BASE + 24'd4, 16'h000A, "b2b stat");
        issue_read(24'hFFFFFF, 16'h0000, "b2b unmapped");
        drain("b2b");

        // Write and read together: write happens, read dropped
        rv_mark    = rv_seen;
        core_we    = 1'b1;
        core_re    = 1'b1;
        core_addr  = BASE + 24'd4;
        core_wdata = 16'h0002;
        tick();
        core_we = 1'b0;
        core_re = 1'b0;
        check_output("we+re write done", periph_fresh, 4'b1000);
        tick();
        tick();
        tick();
        check_output("we+re read dropped", rv_seen - rv_mark, 0);

        // Update beats same-cycle W1C
        periph_data[3*16 +: 16] = 16'h5555;
        periph_upd = 4'b1000;
        write_word(BASE + 24'd4, 16'h0008);
        periph_upd = 4'b0000;
        check_output("upd beats W1C", periph_fresh, 4'b1000);

        // Writes to channels and unmapped space are ignored
        core_we    = 1'b1;
        core_addr  = BASE;
        core_wdata = 16'hDEAD;
        #1;
        check_output("ram_we on CH write", ram_we, 0);
        tick();
        core_addr = 24'h009000;
        #1;
        check_output("ram_we on unmapped write", ram_we, 0);
        tick();
        core_we = 1'b0;
        issue_read(BASE, 16'h1111, "ch0 after write");
        issue_read(BASE + 24'd3, 16'h5555, "ch3 read");
        drain("ignored writes");

        // Reset while a read sits in stage 1
        rv_mark   = rv_seen;
        core_re   = 1'b1;
        core_addr = 24'h000010;
        tick();
        core_re = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check_output("reset mid-pipe no rvalid", rv_seen - rv_mark, 0);
        check_output("fresh after reset", periph_fresh, 4'b0000);
        issue_read(BASE + 24'd3, 16'h0000, "ch3 after reset");
        drain("reset");

`ifdef MMIO_ERR_EN
        // Error counter saturation and clear
        check_output("err_cnt after reset", err_cnt, 8'h00);
        for (int i = 0; i < 300; i++) issue_read(24'h00A000, 16'h0000, "unmapped");
        drain("err");
        check_output("err_cnt saturated", err_cnt, 8'hFF);
        check_output("err_flag set", err_flag, 1);
        write_word(BASE + 24'd4, 16'h8000);
        check_output("err_cnt cleared", err_cnt, 8'h00);
        check_output("err_flag cleared", err_flag, 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
